// File: rtl/mux9to1v_pkg.sv
// Shared constants for the 9-to-1 word multiplexer: highest legal select and
// the fill bit driven on dout for an out-of-range select.
package mux9to1v_pkg;

  localparam logic [3:0] MUX9_SEL_MAX  = 4'd8;
  localparam logic       MUX9_FILL_BIT = 1'b1;

  function automatic logic mux9_sel_is_invalid(input logic [3:0] sel);
    return sel > MUX9_SEL_MAX;
  endfunction

endpackage

// File: rtl/mux9to1v.sv
// 9-to-1 multiplexer of WIDTH-bit words with all-ones fill for illegal selects
// and an optional single output register stage.
module mux9to1v
  import mux9to1v_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int REGISTERED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic [WIDTH-1:0] i,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] dout,
  output logic             sel_invalid
);

  logic [WIDTH-1:0] dout_p0;
  logic             sel_invalid_p0;

  // Stage p0: combinational select
  always_comb begin
    dout_p0        = {WIDTH{MUX9_FILL_BIT}};
    sel_invalid_p0 = mux9_sel_is_invalid(sel);
    case (sel)
      4'd0:    dout_p0 = a;
      4'd1:    dout_p0 = b;
      4'd2:    dout_p0 = c;
      4'd3:    dout_p0 = d;
      4'd4:    dout_p0 = e;
      4'd5:    dout_p0 = f;
      4'd6:    dout_p0 = g;
      4'd7:    dout_p0 = h;
      4'd8:    dout_p0 = i;
      default: dout_p0 = {WIDTH{MUX9_FILL_BIT}};
    endcase
  end

  generate
    if (REGISTERED != 0) begin : g_reg
      logic [WIDTH-1:0] dout_p1;
      logic             sel_invalid_p1;

      // Stage p1: output register; reset clears the held word as well
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_p1        <= '0;
          sel_invalid_p1 <= 1'b0;
        end else begin
          dout_p1        <= dout_p0;
          sel_invalid_p1 <= sel_invalid_p0;
        end
      end

      assign dout        = dout_p1;
      assign sel_invalid = sel_invalid_p1;
    end else begin : g_comb
      // Clock and reset have no function in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};

      assign dout        = dout_p0;
      assign sel_invalid = sel_invalid_p0;
    end
  endgenerate

endmodule

// File: tb/tb_mux9to1v.sv
// Bench for mux9to1v: combinational and registered builds side by side,
// directed vector table, reset sequences and random vectors on both edges.
module tb_mux9to1v;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [8:0][15:0] w;
  logic [15:0]      a, b, c, d, e, f, g, h, i;
  logic [3:0]       sel;
  logic [15:0]      dout_c, dout_r;
  logic             inv_c, inv_r;

  assign a = w[0];
  assign b = w[1];
  assign c = w[2];
  assign d = w[3];
  assign e = w[4];
  assign f = w[5];
  assign g = w[6];
  assign h = w[7];
  assign i = w[8];

  mux9to1v #(.WIDTH(16), .REGISTERED(0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
    .sel(sel), .dout(dout_c), .sel_invalid(inv_c)
  );

  mux9to1v #(.WIDTH(16), .REGISTERED(1)) dut_r (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
    .sel(sel), .dout(dout_r), .sel_invalid(inv_r)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if ($isunknown(act) || act !== exp) begin
      errors++;
      $display("FAIL %s: got %h (invalid,dout) expected %h", name, act, exp);
    end
  endtask

  // Reference: {sel_invalid, dout}
  function automatic logic [16:0] model(input logic [8:0][15:0] ws, input logic [3:0] s);
    if (s < 4'd9) return {1'b0, ws[s]};
    return {1'b1, 16'hffff};
  endfunction

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] exp_dout;
    logic        exp_inv;
  } vec_t;

  vec_t vecs[11];

  task automatic load_fixed_words();
    w[0] = 16'h000a; w[1] = 16'h000b; w[2] = 16'h000c;
    w[3] = 16'h000d; w[4] = 16'h000e; w[5] = 16'h000f;
    w[6] = 16'h0011; w[7] = 16'h0012; w[8] = 16'h0013;
  endtask

  initial begin
    logic [16:0] exp_r;

    vecs[0]  = '{4'd0,  16'h000a, 1'b0};
    vecs[1]  = '{4'd1,  16'h000b, 1'b0};
    vecs[2]  = '{4'd2,  16'h000c, 1'b0};
    vecs[3]  = '{4'd3,  16'h000d, 1'b0};
    vecs[4]  = '{4'd4,  16'h000e, 1'b0};
    vecs[5]  = '{4'd7,  16'h0012, 1'b0};
    vecs[6]  = '{4'd8,  16'h0013, 1'b0};
    vecs[7]  = '{4'd9,  16'hffff, 1'b1};
    vecs[8]  = '{4'd10, 16'hffff, 1'b1};
    vecs[9]  = '{4'd11, 16'hffff, 1'b1};
    vecs[10] = '{4'd15, 16'hffff, 1'b1};

    rst_n = 1'b0;
    load_fixed_words();
    sel = 4'd2;

    // Reset state of the registered build, across a clock edge
    @(posedge clk); #1;
    check("reset_hold", {inv_r, dout_r}, 17'h0_0000);

    // Release with sel=2: still zero until the first rising edge afterwards
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pre_first_capture", {inv_r, dout_r}, 17'h0_0000);
    @(posedge clk); #1;
    check("first_capture_sel2", {inv_r, dout_r}, 17'h0_000c);

    // Directed table, combinational build
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      sel = vecs[k].sel;
      #1;
      check($sformatf("table_sel%0d", vecs[k].sel), {inv_c, dout_c},
            {vecs[k].exp_inv, vecs[k].exp_dout});
    end

    // Registered build: illegal select captured after one edge
    @(negedge clk);
    sel = 4'd12;
    #1;
    check("reg_latency_old", {inv_r, dout_r}, 17'h1_ffff);
    @(negedge clk);
    sel = 4'd5;
    #1;
    check("reg_before_edge", {inv_r, dout_r}, 17'h1_ffff);
    @(posedge clk); #1;
    check("reg_sel5", {inv_r, dout_r}, 17'h0_000f);

    // Asynchronous reset mid-cycle discards the held value
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", {inv_r, dout_r}, 17'h0_0000);
    check("comb_ignores_reset", {inv_c, dout_c}, 17'h0_000f);
    @(posedge clk); #1;
    check("reset_held_edge", {inv_r, dout_r}, 17'h0_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Random vectors changed on both edges
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      exp_r = model(w, sel);
      #1;
      if (n > 0) check("rand_reg", {inv_r, dout_r}, exp_r);
      for (int k = 0; k < 9; k++) w[k] = 16'($urandom);
      sel = 4'($urandom_range(0, 15));
      #1;
      check("rand_comb_pos", {inv_c, dout_c}, model(w, sel));
      @(negedge clk);
      for (int k = 0; k < 9; k++) w[k] = 16'($urandom);
      sel = 4'($urandom_range(0, 15));
      #1;
      check("rand_comb_neg", {inv_c, dout_c}, model(w, sel));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
